// File: rtl/reg_part_fill_arbiter.sv
// Purpose: per-lane round-robin arbitration of R slice writers into an L-lane register; offers the full word downstream.
// Latency: a lane write at cycle t is visible at t+1; the last lane write at t gives OUT_valid at t+1; drain costs one bubble.
// Backpressure: OUT_req_ready drops for filled lanes and for every requester while a complete word waits on IN_ready.
// Build option: define REGPART_OVERWRITE_EN to keep filled lanes writable during FILL (last write wins).
module reg_part_fill_arbiter #(
    parameter int N = 4,
    parameter int L = 4,
    parameter int R = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [R-1:0]                          IN_req_valid,
    input  logic [R*((L > 1) ? $clog2(L) : 1)-1:0] IN_req_lane,
    input  logic [R*N-1:0]                        IN_req_dat,
    output logic [R-1:0]                          OUT_req_ready,
    output logic [L*N-1:0]                        OUT_dat,
    output logic [L-1:0]                          OUT_fill,
    output logic                                  OUT_valid,
    input  logic                                  IN_ready
);

    localparam int LW = (L > 1) ? $clog2(L) : 1;
    localparam int RW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [L*N-1:0]   dat_q, dat_d;
    logic [L-1:0]     fill_q, fill_d;
    logic [RW-1:0]    rr_q [L];
    logic [RW-1:0]    rr_d [L];

    logic [R-1:0]     hit [L];      // hit[l][r]: requester r is valid and targets lane l
    logic [L-1:0]     lane_open;    // lane may accept a write this cycle
    logic [L-1:0]     win_vld;      // lane has at least one candidate
    logic [RW-1:0]    win_sel [L];  // winning requester index per lane
    logic [L-1:0]     lane_wr;      // lane is written at the next edge
    logic [R-1:0]     ready;

    // Round-robin index: base + off, wrapped at R (off is always < R here).
    function automatic logic [RW-1:0] rr_idx(input logic [RW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= R) begin
            s = s - R;
        end
        return RW'(s);
    endfunction

    // Candidate matrix; lane indices >= L never match any lane, so such requests are ignored.
    always_comb begin
        for (int l = 0; l < L; l++) begin
            hit[l] = '0;
            for (int r = 0; r < R; r++) begin
                hit[l][r] = IN_req_valid[r] &&
                            ({{(32-LW){1'b0}}, IN_req_lane[r*LW +: LW]} == $unsigned(l));
            end
        end
    end

    // Which lanes can take a write: only in FILL, and only unfilled lanes unless overwrite is built in.
    always_comb begin
        lane_open = '0;
        for (int l = 0; l < L; l++) begin
`ifdef REGPART_OVERWRITE_EN
            lane_open[l] = (state_q == FILL);
`else
            lane_open[l] = (state_q == FILL) && !fill_q[l];
`endif
        end
    end

    // Per-lane winner: first candidate at or after the lane's pointer, searching upward with wrap.
    always_comb begin
        for (int l = 0; l < L; l++) begin
            win_vld[l] = 1'b0;
            win_sel[l] = '0;
            for (int k = 0; k < R; k++) begin
                if (!win_vld[l] && hit[l][rr_idx(rr_q[l], k)]) begin
                    win_vld[l] = 1'b1;
                    win_sel[l] = rr_idx(rr_q[l], k);
                end
            end
        end
    end

    // Grants: a lane is written when it is open and has a winner; the winner sees ready.
    always_comb begin
        lane_wr = lane_open & win_vld;
        ready   = '0;
        for (int l = 0; l < L; l++) begin
            for (int r = 0; r < R; r++) begin
                if (lane_wr[l] && (win_sel[l] == RW'(r))) begin
                    ready[r] = 1'b1;
                end
            end
        end
    end

    // Next state: lane writes and pointer advance in FILL, word drain in HOLD.
    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        fill_d  = fill_q;
        rr_d    = rr_q;
        case (state_q)
            FILL: begin
                for (int l = 0; l < L; l++) begin
                    if (lane_wr[l]) begin
                        dat_d[l*N +: N] = IN_req_dat[win_sel[l]*N +: N];
                        fill_d[l]       = 1'b1;
                        rr_d[l]         = rr_idx(win_sel[l], 1);
                    end
                end
                if (&fill_d) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Data is left stale on drain; lanes are overwritten as the next word fills.
                if (IN_ready) begin
                    fill_d  = '0;
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            dat_q   <= '0;
            fill_q  <= '0;
            for (int l = 0; l < L; l++) begin
                rr_q[l] <= '0;
            end
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            fill_q  <= fill_d;
            for (int l = 0; l < L; l++) begin
                rr_q[l] <= rr_d[l];
            end
        end
    end

    assign OUT_req_ready = ready;
    assign OUT_dat       = dat_q;
    assign OUT_fill      = fill_q;
    assign OUT_valid     = (state_q == HOLD);

endmodule

// File: tb/tb_reg_part_fill_arbiter.sv
// Directed bench for reg_part_fill_arbiter: N=L=R=4 main instance plus an L=3 instance for out-of-range lanes.
// Inputs change 1ns after the rising edge; outputs are compared after a further 1ns settle.
// Expected values are hand-derived constants; REGPART_OVERWRITE_EN selects the overwrite-mode expectations.
module tb_reg_part_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [7:0]  req_lane  = '0;
    logic [15:0] req_dat   = '0;
    logic [3:0]  req_ready;
    logic [15:0] out_dat;
    logic [3:0]  out_fill;
    logic        out_valid;
    logic        in_ready = 1'b0;

    logic [3:0]  r3_valid = '0;
    logic [7:0]  r3_lane  = '0;
    logic [15:0] r3_dat   = '0;
    logic [3:0]  r3_ready;
    logic [11:0] r3_out_dat;
    logic [2:0]  r3_fill;
    logic        r3_out_valid;
    logic        r3_in_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_part_fill_arbiter #(.N(4), .L(4), .R(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .IN_req_valid  (req_valid),
        .IN_req_lane   (req_lane),
        .IN_req_dat    (req_dat),
        .OUT_req_ready (req_ready),
        .OUT_dat       (out_dat),
        .OUT_fill      (out_fill),
        .OUT_valid     (out_valid),
        .IN_ready      (in_ready)
    );

    reg_part_fill_arbiter #(.N(4), .L(3), .R(4)) dut3 (
        .clk           (clk),
        .rst           (rst),
        .IN_req_valid  (r3_valid),
        .IN_req_lane   (r3_lane),
        .IN_req_dat    (r3_dat),
        .OUT_req_ready (r3_ready),
        .OUT_dat       (r3_out_dat),
        .OUT_fill      (r3_fill),
        .OUT_valid     (r3_out_valid),
        .IN_ready      (r3_in_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [1:0] ln, input logic [3:0] d);
        req_valid[r]      = v;
        req_lane[r*2 +: 2] = ln;
        req_dat[r*4 +: 4]  = d;
    endtask

    initial begin
        // 1. Reset with random requests pending
        rst       = 1'b1;
        req_valid = 4'($urandom);
        req_lane  = 8'($urandom);
        req_dat   = 16'($urandom);
        tick();
        tick();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_valid", 32'(out_valid), 'h0);
        chk("rst_dat",   32'(out_dat),   'h0);
        chk("rst_fill",  32'(out_fill),  'h0);
        chk("rst_rdy",   32'(req_ready), 'h0);

        // 2. Parallel fill: requester r -> lane r, data r+1
        for (int r = 0; r < 4; r++) begin
            set_req(r, 1'b1, 2'(r), 4'(r + 1));
        end
        #1;
        chk("par_rdy", 32'(req_ready), 'hF);
        tick();
        req_valid = '0;
        #1;
        chk("par_valid", 32'(out_valid), 'h1);
        chk("par_dat",   32'(out_dat),   'h4321);
        chk("par_fill",  32'(out_fill),  'hF);
        chk("par_hold_rdy", 32'(req_ready), 'h0);
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        #1;
        chk("par_drain_valid", 32'(out_valid), 'h0);
        chk("par_drain_fill",  32'(out_fill),  'h0);

        // 3. Contention on lane 1 with fresh pointers
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 2'd1, 4'd5);
        set_req(2, 1'b1, 2'd1, 4'd9);
        set_req(1, 1'b1, 2'd0, 4'd1);
        set_req(3, 1'b1, 2'd2, 4'd2);
        #1;
        chk("cont_rdy", 32'(req_ready), 'b1011);
        tick();
        req_valid = '0;
        #1;
        chk("cont_lane1", 32'(out_dat[7:4]), 'h5);
        chk("cont_fill",  32'(out_fill),     'b0111);
        set_req(1, 1'b1, 2'd3, 4'd3);
        #1;
        tick();
        req_valid = '0;
        #1;
        chk("cont_valid", 32'(out_valid), 'h1);
        chk("cont_dat",   32'(out_dat),   'h3251);
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        #1;
        chk("cont_drain", 32'(out_valid), 'h0);
        set_req(0, 1'b1, 2'd1, 4'd5);
        set_req(2, 1'b1, 2'd1, 4'd9);
        #1;
        chk("cont_rr_rdy", 32'(req_ready), 'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("cont_rr_dat",  32'(out_dat),  'h3291);
        chk("cont_rr_fill", 32'(out_fill), 'b0010);

        // 4. Backpressure: complete the word, hold IN_ready low for 5 cycles
        set_req(0, 1'b1, 2'd0, 4'd6);
        set_req(1, 1'b1, 2'd2, 4'd7);
        set_req(3, 1'b1, 2'd3, 4'd8);
        #1;
        chk("bp_fill_rdy", 32'(req_ready), 'b1011);
        tick();
        req_valid = '0;
        set_req(2, 1'b1, 2'd0, 4'hA);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 'h1);
            chk("bp_dat",   32'(out_dat),   'h8796);
            chk("bp_rdy",   32'(req_ready), 'h0);
            tick();
        end
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        #1;
        chk("bp_drain_valid", 32'(out_valid), 'h0);
        chk("bp_drain_fill",  32'(out_fill),  'h0);
        chk("bp_bubble_rdy",  32'(req_ready), 'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("bp_after_fill", 32'(out_fill),     'b0001);
        chk("bp_after_lane0", 32'(out_dat[3:0]), 'hA);

        // 5. Re-write of an already filled lane 0
        set_req(1, 1'b1, 2'd0, 4'd7);
        #1;
`ifdef REGPART_OVERWRITE_EN
        chk("rw_rdy", 32'(req_ready), 'b0010);
        tick();
        req_valid[1] = 1'b0;
        #1;
        chk("rw_lane0", 32'(out_dat[3:0]), 'h7);
        chk("rw_fill",  32'(out_fill),     'b0001);
`else
        chk("rw_rdy", 32'(req_ready), 'b0000);
        tick();
        #1;
        chk("rw_lane0", 32'(out_dat[3:0]), 'hA);
        chk("rw_fill",  32'(out_fill),     'b0001);
        chk("rw_stall_rdy", 32'(req_ready), 'b0000);
`endif
        set_req(0, 1'b1, 2'd1, 4'd1);
        set_req(2, 1'b1, 2'd2, 4'd2);
        set_req(3, 1'b1, 2'd3, 4'd3);
        #1;
        chk("rw_rest_rdy", 32'(req_ready), 'b1101);
        tick();
        req_valid[0] = 1'b0;
        req_valid[2] = 1'b0;
        req_valid[3] = 1'b0;
        #1;
        chk("rw_valid", 32'(out_valid), 'h1);
`ifdef REGPART_OVERWRITE_EN
        chk("rw_dat", 32'(out_dat), 'h3217);
`else
        chk("rw_dat", 32'(out_dat), 'h321A);
`endif
        chk("rw_hold_rdy", 32'(req_ready), 'h0);
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        #1;
`ifdef REGPART_OVERWRITE_EN
        chk("rw_post_rdy",  32'(req_ready), 'b0000);
        chk("rw_post_fill", 32'(out_fill),  'b0000);
`else
        chk("rw_post_rdy", 32'(req_ready), 'b0010);
        tick();
        req_valid = '0;
        #1;
        chk("rw_post_lane0", 32'(out_dat[3:0]), 'h7);
        chk("rw_post_fill",  32'(out_fill),     'b0001);
`endif

        // 6. Reset mid-fill with lane 0 pointer at 2
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = '0;
        set_req(1, 1'b1, 2'd0, 4'd1);
        set_req(0, 1'b1, 2'd1, 4'd2);
        #1;
        chk("mr_pre_rdy", 32'(req_ready), 'b0011);
        tick();
        req_valid = '0;
        #1;
        chk("mr_pre_fill", 32'(out_fill), 'b0011);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mr_fill",  32'(out_fill),  'h0);
        chk("mr_valid", 32'(out_valid), 'h0);
        chk("mr_dat",   32'(out_dat),   'h0);
        set_req(1, 1'b1, 2'd0, 4'd4);
        set_req(3, 1'b1, 2'd0, 4'd5);
        #1;
        chk("mr_rdy", 32'(req_ready), 'b0010);
        tick();
        req_valid = '0;
        #1;
        chk("mr_lane0", 32'(out_dat[3:0]), 'h4);

        // 7. Out-of-range lane on the L=3 instance
        r3_valid = 4'b0011;
        r3_lane  = 8'b0000_1011;
        r3_dat   = 16'h0065;
        #1;
        chk("oor_rdy", 32'(r3_ready), 'b0010);
        tick();
        r3_valid = 4'b0001;
        #1;
        chk("oor_fill", 32'(r3_fill),    'b100);
        chk("oor_dat",  32'(r3_out_dat), 'h600);
        for (int i = 0; i < 3; i++) begin
            chk("oor_hold_rdy",  32'(r3_ready),     'h0);
            chk("oor_hold_fill", 32'(r3_fill),      'b100);
            chk("oor_hold_vld",  32'(r3_out_valid), 'h0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
